// File: rtl/stack_pkg.sv
// Shared definitions for the parametrised operand stack: op encodings and
// the occupancy-counter width helper.
package stack_pkg;

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_PUSH    = 3'd1,
    OP_POP     = 3'd2,
    OP_PEEK    = 3'd3,
    OP_DUP     = 3'd4,
    OP_SWAP    = 3'd5,
    OP_REPLACE = 3'd6,
    OP_CLEAR   = 3'd7
  } stack_op_t;

  // Count must represent 0..DEPTH inclusive.
  function automatic int stack_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/stack_regfile.sv
// Stack storage: two combinational read ports (top, second) and two write
// ports so that SWAP exchanges both entries on a single edge. Not reset.
module stack_regfile #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             we0,
  input  logic [AW-1:0]    wa0,
  input  logic [WIDTH-1:0] wd0,
  input  logic             we1,
  input  logic [AW-1:0]    wa1,
  input  logic [WIDTH-1:0] wd1,
  input  logic [AW-1:0]    ra0,
  input  logic [AW-1:0]    ra1,
  output logic [WIDTH-1:0] rd0,
  output logic [WIDTH-1:0] rd1
);

  logic [WIDTH-1:0] mem [DEPTH];

  // The two write ports never target the same entry in the same cycle.
  always_ff @(negedge clk) begin
    if (we0) mem[wa0] <= wd0;
    if (we1) mem[wa1] <= wd1;
  end

  assign rd0 = mem[ra0];
  assign rd1 = mem[ra1];

endmodule

// File: rtl/param_stack.sv
// Parametrised operand stack: pointer, op decode with legality checks,
// registered result word and sticky error flags. State updates on negedge.
module param_stack
  import stack_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [2:0]                    op,
  input  logic [WIDTH-1:0]              d_in,
  output logic [WIDTH-1:0]              d_out,
  output logic [stack_cnt_w(DEPTH)-1:0] count,
  output logic                          empty,
  output logic                          full,
  output logic                          err_ovf,
  output logic                          err_udf
);

  localparam int CW = stack_cnt_w(DEPTH);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  stack_op_t op_e;

  logic [CW-1:0]    sp_q, sp_d;
  logic [WIDTH-1:0] d_out_q, d_out_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  logic             is_empty, is_full, lt_two;
  logic [AW-1:0]    push_idx, top_idx, sec_idx;
  logic [WIDTH-1:0] top_val, sec_val;

  logic             we0, we1;
  logic [AW-1:0]    wa0, wa1;
  logic [WIDTH-1:0] wd0, wd1;

  assign op_e     = stack_op_t'(op);
  assign is_empty = (sp_q == '0);
  assign is_full  = (sp_q == CW'(DEPTH));
  assign lt_two   = (sp_q < CW'(2));

  // Modular AW-bit arithmetic gives the right index whenever it is in range;
  // out-of-range cases are parked at entry 0 and never consumed.
  assign push_idx = is_full  ? '0 : sp_q[AW-1:0];
  assign top_idx  = is_empty ? '0 : sp_q[AW-1:0] - AW'(1);
  assign sec_idx  = lt_two   ? '0 : sp_q[AW-1:0] - AW'(2);

  stack_regfile #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_regfile (
    .clk (clk),
    .we0 (we0),
    .wa0 (wa0),
    .wd0 (wd0),
    .we1 (we1),
    .wa1 (wa1),
    .wd1 (wd1),
    .ra0 (top_idx),
    .ra1 (sec_idx),
    .rd0 (top_val),
    .rd1 (sec_val)
  );

  always_comb begin
    sp_d    = sp_q;
    d_out_d = d_out_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    we0     = 1'b0;
    wa0     = push_idx;
    wd0     = d_in;
    we1     = 1'b0;
    wa1     = sec_idx;
    wd1     = top_val;

    case (op_e)
      OP_PUSH: begin
        if (is_full) begin
          ovf_d = 1'b1;
        end else begin
          we0     = 1'b1;
          sp_d    = sp_q + CW'(1);
          d_out_d = d_in;
        end
      end
      OP_POP: begin
        if (is_empty) begin
          udf_d = 1'b1;
        end else begin
          sp_d    = sp_q - CW'(1);
          d_out_d = top_val;
        end
      end
      OP_PEEK: begin
        if (is_empty) udf_d = 1'b1;
        else          d_out_d = top_val;
      end
      OP_DUP: begin
        if (is_empty) begin
          udf_d = 1'b1;
        end else if (is_full) begin
          ovf_d = 1'b1;
        end else begin
          we0     = 1'b1;
          wd0     = top_val;
          sp_d    = sp_q + CW'(1);
          d_out_d = top_val;
        end
      end
      OP_SWAP: begin
        if (lt_two) begin
          udf_d = 1'b1;
        end else begin
          we0     = 1'b1;
          wa0     = top_idx;
          wd0     = sec_val;
          we1     = 1'b1;
          d_out_d = sec_val;
        end
      end
      OP_REPLACE: begin
        if (is_empty) begin
          udf_d = 1'b1;
        end else begin
          we0     = 1'b1;
          wa0     = top_idx;
          d_out_d = top_val;
        end
      end
      OP_CLEAR: begin
        sp_d  = '0;
        ovf_d = 1'b0;
        udf_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      sp_q    <= '0;
      d_out_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      sp_q    <= sp_d;
      d_out_q <= d_out_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign d_out   = d_out_q;
  assign count   = sp_q;
  assign empty   = is_empty;
  assign full    = is_full;
  assign err_ovf = ovf_q;
  assign err_udf = udf_q;

endmodule

// File: tb/tb_param_stack.sv
// Directed bench for param_stack (WIDTH=8, DEPTH=4) with hand-computed
// expectations for each operation and the asynchronous reset case.
module tb_param_stack;
  import stack_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = stack_cnt_w(DEPTH);

  logic             clk;
  logic             rst;
  logic [2:0]       op;
  logic [WIDTH-1:0] d_in;
  logic [WIDTH-1:0] d_out;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             err_ovf;
  logic             err_udf;

  int n_checks = 0;
  int n_errors = 0;

  param_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .op      (op),
    .d_in    (d_in),
    .d_out   (d_out),
    .count   (count),
    .empty   (empty),
    .full    (full),
    .err_ovf (err_ovf),
    .err_udf (err_udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Compares the whole visible state; empty/full follow from the expected count.
  task automatic expect_state(input string tag, input logic [7:0] e_dout, input int e_cnt,
                              input logic e_ovf, input logic e_udf);
    check({tag, ".d_out"}, 32'(d_out), 32'(e_dout));
    check({tag, ".count"}, 32'(count), 32'(e_cnt));
    check({tag, ".empty"}, 32'(empty), 32'(e_cnt == 0));
    check({tag, ".full"},  32'(full),  32'(e_cnt == DEPTH));
    check({tag, ".ovf"},   32'(err_ovf), 32'(e_ovf));
    check({tag, ".udf"},   32'(err_udf), 32'(e_udf));
  endtask

  // Drive after the rising edge, let the falling edge act, sample 1 ns later.
  task automatic do_op(input logic [2:0] o, input logic [7:0] d);
    @(posedge clk);
    op   = o;
    d_in = d;
    @(negedge clk);
    #1;
    $display("t=%0t op=%0d d_in=0x%02h -> d_out=0x%02h count=%0d empty=%0b full=%0b ovf=%0b udf=%0b",
             $time, o, d, d_out, count, empty, full, err_ovf, err_udf);
    op = OP_NOP;
  endtask

  initial begin
    rst  = 1'b1;
    op   = OP_NOP;
    d_in = '0;
    repeat (2) @(negedge clk);
    #1;
    expect_state("reset", 8'h00, 0, 1'b0, 1'b0);
    @(posedge clk);
    rst = 1'b0;

    // Basic push/pop ordering
    do_op(OP_PUSH, 8'h15); expect_state("push15", 8'h15, 1, 1'b0, 1'b0);
    do_op(OP_PUSH, 8'h3F); expect_state("push3f", 8'h3F, 2, 1'b0, 1'b0);
    do_op(OP_POP,  8'h00); expect_state("pop1",   8'h3F, 1, 1'b0, 1'b0);
    do_op(OP_POP,  8'h00); expect_state("pop2",   8'h15, 0, 1'b0, 1'b0);

    // Underflow on empty, d_out holds, CLEAR drops the flag
    do_op(OP_POP,  8'h00); expect_state("pop_empty",  8'h15, 0, 1'b0, 1'b1);
    do_op(OP_PEEK, 8'h00); expect_state("peek_empty", 8'h15, 0, 1'b0, 1'b1);
    do_op(OP_CLEAR, 8'h00); expect_state("clear1",    8'h15, 0, 1'b0, 1'b0);

    // Fill to DEPTH, then overflow
    for (int i = 1; i <= DEPTH; i++) do_op(OP_PUSH, 8'(i));
    expect_state("fill", 8'h04, 4, 1'b0, 1'b0);
    do_op(OP_PUSH, 8'h05); expect_state("push_full", 8'h04, 4, 1'b1, 1'b0);
    do_op(OP_DUP,  8'h00); expect_state("dup_full",  8'h04, 4, 1'b1, 1'b0);
    do_op(OP_POP,  8'h00); expect_state("pop_after_ovf", 8'h04, 3, 1'b1, 1'b0);
    do_op(OP_PEEK, 8'h00); expect_state("peek3", 8'h03, 3, 1'b1, 1'b0);
    do_op(OP_CLEAR, 8'h00); expect_state("clear2", 8'h03, 0, 1'b0, 1'b0);

    // SWAP
    do_op(OP_PUSH, 8'hA0);
    do_op(OP_PUSH, 8'hB0);
    do_op(OP_SWAP, 8'h00); expect_state("swap",      8'hA0, 2, 1'b0, 1'b0);
    do_op(OP_POP,  8'h00); expect_state("swap_pop1", 8'hA0, 1, 1'b0, 1'b0);
    do_op(OP_POP,  8'h00); expect_state("swap_pop2", 8'hB0, 0, 1'b0, 1'b0);
    do_op(OP_PUSH, 8'h33);
    do_op(OP_SWAP, 8'h00); expect_state("swap_one", 8'h33, 1, 1'b0, 1'b1);
    do_op(OP_CLEAR, 8'h00);

    // DUP and REPLACE
    do_op(OP_DUP,  8'h00); expect_state("dup_empty", 8'h33, 0, 1'b0, 1'b1);
    do_op(OP_REPLACE, 8'h44); expect_state("repl_empty", 8'h33, 0, 1'b0, 1'b1);
    do_op(OP_CLEAR, 8'h00);
    do_op(OP_PUSH, 8'h11);
    do_op(OP_DUP,  8'h00); expect_state("dup",     8'h11, 2, 1'b0, 1'b0);
    do_op(OP_REPLACE, 8'h22); expect_state("replace", 8'h11, 2, 1'b0, 1'b0);
    do_op(OP_POP,  8'h00); expect_state("repl_pop1", 8'h22, 1, 1'b0, 1'b0);
    do_op(OP_POP,  8'h00); expect_state("repl_pop2", 8'h11, 0, 1'b0, 1'b0);
    do_op(OP_NOP,  8'h5A); expect_state("nop", 8'h11, 0, 1'b0, 1'b0);

    // Asynchronous reset mid-cycle while a PUSH is presented at count=3
    do_op(OP_PUSH, 8'hC1);
    do_op(OP_PUSH, 8'hC2);
    do_op(OP_PUSH, 8'hC3); expect_state("pre_rst", 8'hC3, 3, 1'b0, 1'b0);
    @(posedge clk);
    op   = OP_PUSH;
    d_in = 8'hC4;
    #2;
    rst = 1'b1;
    #1;
    expect_state("async_rst", 8'h00, 0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    expect_state("rst_hold", 8'h00, 0, 1'b0, 1'b0);
    @(posedge clk);
    rst = 1'b0;
    op  = OP_NOP;
    do_op(OP_PUSH, 8'h7E); expect_state("post_rst_push", 8'h7E, 1, 1'b0, 1'b0);
    do_op(OP_PUSH, 8'h99);
    do_op(OP_POP,  8'h00); expect_state("post_rst_pop1", 8'h99, 1, 1'b0, 1'b0);
    do_op(OP_POP,  8'h00); expect_state("post_rst_pop2", 8'h7E, 0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish before 100000");
    n_errors++;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/param_stack.md
# param_stack

Parametrised hardware operand stack for the stack-based processor datapath, replacing the fixed 8-bit/32-entry stack. It adds WIDTH/DEPTH parameters, an encoded operation port with DUP, SWAP, REPLACE and CLEAR, occupancy flags, and sticky overflow/underflow error reporting. It sits between the controller, which issues one operation per cycle, and the ALU operand registers, which sample `d_out`.

## Interface
- `WIDTH`, 8: data word width in bits.
- `DEPTH`, 32: number of entries, ≥ 2; need not be a power of two.
- `clk`  in  1  clock; all state updates on the falling edge, so results are stable for the controller's rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `op`  in  3  operation code: 0 NOP, 1 PUSH, 2 POP, 3 PEEK, 4 DUP, 5 SWAP, 6 REPLACE, 7 CLEAR.
- `d_in`  in  WIDTH  data for PUSH/REPLACE.
- `d_out`  out  WIDTH  registered result word.
- `count`  out  $clog2(DEPTH+1)  current occupancy.
- `empty`  out  1  count == 0.
- `full`  out  1  count == DEPTH.
- `err_ovf`  out  1  sticky overflow.
- `err_udf`  out  1  sticky underflow.

## Operation
Pointer `sp` equals `count`; the top entry is `mem[sp-1]` and the second entry is `mem[sp-2]`. Legal operations:
- PUSH: `mem[sp] <= d_in`; sp+1; `d_out <= d_in`.
- POP: sp-1; `d_out <=` old top (the popped value).
- PEEK: `d_out <=` top; sp unchanged.
- DUP: `mem[sp] <=` top; sp+1; `d_out <=` top.
- SWAP: top and second are exchanged in one edge; `d_out <=` new top (old second).
- REPLACE (pop+push fused): `mem[sp-1] <= d_in`; sp unchanged; `d_out <=` old top.
- CLEAR: sp <= 0; err_ovf/err_udf <= 0; `d_out` unchanged; memory contents untouched.
- NOP: no state change.

Illegal operations are fully suppressed: no memory write, no sp change, and `d_out` holds.
- Overflow: PUSH or DUP when full. Sets err_ovf.
- Underflow: POP, PEEK or REPLACE when empty, DUP when empty, or SWAP with count < 2. Sets err_udf.
- DUP when both empty and full is impossible because DEPTH ≥ 2.

Error flags are sticky. They clear only on rst or CLEAR, and CLEAR takes precedence over setting them.

Arithmetic: sp never wraps; it is saturated by the legality checks above. Indices sp-1 and sp-2 are evaluated only when legal, which avoids out-of-range reads.

## Timing
- Every operation completes at a single falling clk edge, with one op per cycle and no stall or handshake. `d_out`, `count`, flags and memory all reflect the op after that edge.
- empty/full are decoded combinationally from the registered count, so they carry no extra latency.
- Back-to-back ops see the state left by the previous edge. PUSH followed by POP returns the pushed word.
- Reset values: `d_out`=0, count=0, empty=1, full=0, err_ovf=0, err_udf=0. Memory is not reset.
- rst asserted mid-stream takes effect immediately (asynchronous) and overrides any op on that edge. The first op is accepted at the first falling edge after rst deasserts.

## Structure
- Package `stack_pkg` holds:
  - the op enum `stack_op_t` (3 bits, encodings above);
  - a `stack_cnt_w(DEPTH)` helper returning $clog2(DEPTH+1).
- Sub-module `stack_regfile`: DEPTH×WIDTH array with two combinational read ports (top, second) and two write ports, so SWAP can complete in one edge. No reset on the array.
- Top level holds sp, the op decode/legality logic, `d_out` and the error flags.

## Test plan
- Reset then PUSH 0x15, PUSH 0x3F, POP → `d_out`=0x3F, count=1. Then POP → `d_out`=0x15, empty=1.
- Empty POP and PEEK → err_udf=1, count=0, `d_out` unchanged. Then CLEAR → err_udf=0.
- DEPTH=4: push 0x01..0x04 → full=1. A 5th PUSH of 0x05 → err_ovf=1, count=4. Then POP → `d_out`=0x04.
- PUSH 0xA0, PUSH 0xB0, SWAP → `d_out`=0xA0. POP, POP → 0xA0 then 0xB0. SWAP with count=1 → err_udf.
- PUSH 0x11, DUP, REPLACE with `d_in`=0x22 → `d_out`=0x11, count=2. POP → 0x22, POP → 0x11.
- Assert rst asynchronously between edges during a PUSH sequence at count=3 → count=0, `d_out`=0 immediately. The next PUSH 0x7E lands at entry 0.
